// File: rtl/mux_n_1_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n_1_reg_if
//  Description : Bundle of every non-clock, non-reset signal of the registered
//                N-to-1 stream multiplexer: the enable/mode/select controls,
//                the N input channels and the single output channel.
//                The slave view is the multiplexer itself. The master view is
//                the surrounding logic, which drives the channels and the
//                controls and consumes the output.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_n_1_reg_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16
) ();
    localparam int SELW = $clog2(N);

    // Controls
    logic                 en;
    logic                 rr_mode;
    logic [SELW-1:0]      sel;

    // Input channels, channel i at bits [i*WIDTH +: WIDTH]
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;

    // Output channel
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_src;

    // Multiplexer side
    modport slave (
        input  en,
        input  rr_mode,
        input  sel,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_src
    );

    // Producer / consumer / control side
    modport master (
        output en,
        output rr_mode,
        output sel,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_src
    );
endinterface
`default_nettype wire

// File: rtl/mux_n_1_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n_1_reg
//  Description : Parametrised N-to-1, WIDTH-bit registered stream multiplexer.
//                Picks one valid input channel, either the one named by sel
//                (fixed mode) or the first valid one at or above a rotating
//                pointer (round-robin mode), and loads it into a single
//                output register with valid/ready handshaking. A word can be
//                consumed and replaced on the same edge, giving one transfer
//                per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_n_1_reg #(
    parameter int WIDTH = 16,
    parameter int N     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_n_1_reg_if.slave  bus
);
    localparam int SELW = $clog2(N);

    // N and the last channel index held at the widths used in the compares.
    localparam logic [SELW:0]   N_EXT   = (SELW + 1)'(N);
    localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SELW-1:0]  ptr;          // round-robin search start
    logic             held_valid;   // output register occupied
    logic [WIDTH-1:0] held_data;    // output register word
    logic [SELW-1:0]  held_src;     // channel that produced held_data

    // ------------------------------------------------------------------
    // Combinational grant path
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] chan_data [N];   // unpacked channel words
    logic [SELW:0]    chan_dist [N];   // upward distance from ptr to channel

    logic             slot_free;
    logic             fix_hit;
    logic [SELW-1:0]  fix_idx;
    logic             rr_hit;
    logic [SELW-1:0]  rr_idx;
    logic [SELW:0]    best_dist;
    logic             grant_hit;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             accept;
    logic [N-1:0]     ready_vec;
    logic [SELW-1:0]  ptr_next;

    // Per-channel data slice and wrap-around distance from the pointer.
    // Distance 0 is the pointer's own channel, N-1 the one just below it,
    // so the smallest distance among valid channels is the round-robin winner.
    // The extra bit keeps i + N - ptr from overflowing.
    generate
        for (genvar i = 0; i < N; i++) begin : g_chan
            localparam logic [SELW:0] I_EXT = (SELW + 1)'(i);
            assign chan_data[i] = bus.in_data[i*WIDTH +: WIDTH];
            assign chan_dist[i] = (I_EXT >= {1'b0, ptr})
                                ? (I_EXT - {1'b0, ptr})
                                : (I_EXT + N_EXT - {1'b0, ptr});
        end
    endgenerate

    // The output register can take a new word if it is empty or is being
    // drained on this very edge.
    assign slot_free = !held_valid || bus.out_ready;

    // Fixed mode: only the selected channel may win; a sel that names no
    // channel (possible when N is not a power of two) matches nothing.
    always_comb begin
        fix_hit = 1'b0;
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
                fix_hit = 1'b1;
                fix_idx = SELW'(i);
            end
        end
    end

    // Round-robin mode: closest valid channel at or above ptr, wrapping.
    always_comb begin
        rr_hit    = 1'b0;
        rr_idx    = '0;
        best_dist = N_EXT;
        for (int i = 0; i < N; i++) begin
            if (bus.in_valid[i] && (chan_dist[i] < best_dist)) begin
                rr_hit    = 1'b1;
                rr_idx    = SELW'(i);
                best_dist = chan_dist[i];
            end
        end
    end

    assign grant_hit = bus.rr_mode ? rr_hit : fix_hit;
    assign grant_idx = bus.rr_mode ? rr_idx : fix_idx;

    // rst_n is part of the acceptance term so that in_ready reads 0 for the
    // whole time reset is held, not just after the next edge.
    assign accept = rst_n && bus.en && slot_free && grant_hit;

    // Winner's data word.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = chan_data[i];
            end
        end
    end

    // One-hot ready to the accepted channel, all zero otherwise.
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < N; i++) begin
            if (accept && (grant_idx == SELW'(i))) begin
                ready_vec[i] = 1'b1;
            end
        end
    end

    // Search restarts just above the channel that won, wrapping N-1 -> 0.
    assign ptr_next = (grant_idx == LAST_CH) ? '0 : (grant_idx + SELW'(1));

    // ------------------------------------------------------------------
    // Output register and round-robin pointer
    // ------------------------------------------------------------------
    // Load on acceptance (also covers consume-and-replace), clear valid on a
    // bare consume, otherwise hold. The pointer moves only on round-robin
    // acceptances, so fixed mode and en = 0 leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid <= 1'b0;
            held_data  <= '0;
            held_src   <= '0;
            ptr        <= '0;
        end else begin
            if (accept) begin
                held_valid <= 1'b1;
                held_data  <= grant_data;
                held_src   <= grant_idx;
                if (bus.rr_mode) begin
                    ptr <= ptr_next;
                end
            end else if (held_valid && bus.out_ready) begin
                held_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready_vec;
    assign bus.out_data  = held_data;
    assign bus.out_valid = held_valid;
    assign bus.out_src   = held_src;

endmodule
`default_nettype wire

// File: tb/tb_mux_n_1_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_n_1_reg
//  Description : Self-checking bench for mux_n_1_reg. Two instances are
//                exercised: N=4/WIDTH=16 and N=3/WIDTH=32. Every cycle is
//                compared against a transaction-level reference model
//                (output slot, pointer, winner search by modular arithmetic).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_n_1_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_n_1_reg_if #(.N(4), .WIDTH(16)) b4 ();
    mux_n_1_reg_if #(.N(3), .WIDTH(32)) b3 ();

    mux_n_1_reg #(.WIDTH(16), .N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    mux_n_1_reg #(.WIDTH(32), .N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    int tests = 0;
    int fails = 0;

    // Reference model state, index 0 = N4 instance, 1 = N3 instance
    bit          mv [2];
    logic [31:0] md [2];
    int          ms [2];
    int          mp [2];

    localparam logic [63:0] SEQ4 = 64'h0003_0002_0001_0000;
    localparam logic [95:0] SEQ3 = 96'h00000002_00000001_00000000;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nch(input int id);
        return (id == 0) ? 4 : 3;
    endfunction

    // Winner for this cycle, or -1 when nothing is accepted.
    function automatic int model_grant(input int id, input bit en, input bit rr,
                                       input int sel, input logic [3:0] vld, input bit ordy);
        int n;
        n = nch(id);
        if (!en) return -1;
        if (mv[id] && !ordy) return -1;
        if (!rr) begin
            if (sel < n && vld[sel]) return sel;
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            if (vld[(mp[id] + k) % n]) return (mp[id] + k) % n;
        end
        return -1;
    endfunction

    task automatic model_edge(input int id, input int g, input bit rr, input bit ordy,
                              input logic [31:0] word);
        if (g >= 0) begin
            mv[id] = 1'b1;
            md[id] = word;
            ms[id] = g;
            if (rr) mp[id] = (g + 1) % nch(id);
        end else if (mv[id] && ordy) begin
            mv[id] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            mv[id] = 1'b0; md[id] = '0; ms[id] = 0; mp[id] = 0;
        end
    endtask

    // One cycle on the N=4 instance: entered and left at a falling edge.
    task automatic step4(input string tag, input bit en, input bit rr, input int sel,
                         input logic [3:0] vld, input logic [63:0] data, input bit ordy);
        int g;
        logic [15:0] word;
        b4.en = en; b4.rr_mode = rr; b4.sel = 2'(sel);
        b4.in_valid = vld; b4.in_data = data; b4.out_ready = ordy;
        #1;
        g = model_grant(0, en, rr, sel, vld, ordy);
        word = '0;
        if (g >= 0) word = data[g*16 +: 16];
        check({tag, ".in_ready"}, 64'(b4.in_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
        @(posedge clk);
        model_edge(0, g, rr, ordy, 32'(word));
        #1;
        check({tag, ".out_valid"}, 64'(b4.out_valid), 64'(mv[0]));
        check({tag, ".out_data"},  64'(b4.out_data),  64'(md[0][15:0]));
        check({tag, ".out_src"},   64'(b4.out_src),   64'(ms[0]));
        @(negedge clk);
    endtask

    // One cycle on the N=3 instance.
    task automatic step3(input string tag, input bit en, input bit rr, input int sel,
                         input logic [2:0] vld, input logic [95:0] data, input bit ordy);
        int g;
        logic [31:0] word;
        b3.en = en; b3.rr_mode = rr; b3.sel = 2'(sel);
        b3.in_valid = vld; b3.in_data = data; b3.out_ready = ordy;
        #1;
        g = model_grant(1, en, rr, sel, {1'b0, vld}, ordy);
        word = '0;
        if (g >= 0) word = data[g*32 +: 32];
        check({tag, ".in_ready"}, 64'(b3.in_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
        @(posedge clk);
        model_edge(1, g, rr, ordy, word);
        #1;
        check({tag, ".out_valid"}, 64'(b3.out_valid), 64'(mv[1]));
        check({tag, ".out_data"},  64'(b3.out_data),  64'(md[1]));
        check({tag, ".out_src"},   64'(b3.out_src),   64'(ms[1]));
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".n4_valid"}, 64'(b4.out_valid), 64'd0);
        check({tag, ".n4_data"},  64'(b4.out_data),  64'd0);
        check({tag, ".n4_src"},   64'(b4.out_src),   64'd0);
        check({tag, ".n4_ready"}, 64'(b4.in_ready),  64'd0);
        check({tag, ".n3_valid"}, 64'(b3.out_valid), 64'd0);
        check({tag, ".n3_data"},  64'(b3.out_data),  64'd0);
        check({tag, ".n3_src"},   64'(b3.out_src),   64'd0);
        check({tag, ".n3_ready"}, 64'(b3.in_ready),  64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_seq [5];
        int alt_seq [4];
        int n3_seq [4];
        exp_seq = '{0, 1, 2, 3, 0};
        alt_seq = '{3, 1, 3, 1};
        n3_seq  = '{0, 1, 2, 0};

        // Reset with all channels offering data: ready must still be 0
        rst_n = 1'b0;
        b4.en = 1'b1; b4.rr_mode = 1'b1; b4.sel = '0; b4.in_valid = 4'hF;
        b4.in_data = SEQ4; b4.out_ready = 1'b1;
        b3.en = 1'b1; b3.rr_mode = 1'b1; b3.sel = '0; b3.in_valid = 3'h7;
        b3.in_data = SEQ3; b3.out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        b3.in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed mode
        step4("fix_sel2", 1, 0, 2, 4'b0100, 64'h0000_BEEF_0000_0000, 1);
        check("fix_sel2.const_data", 64'(b4.out_data), 64'hBEEF);
        check("fix_sel2.const_src",  64'(b4.out_src),  64'd2);
        step4("fix_sel3", 1, 0, 3, 4'b0100, 64'h0000_BEEF_0000_0000, 1);
        check("fix_sel3.const_valid", 64'(b4.out_valid), 64'd0);

        // Round-robin, all channels valid from ptr 0
        for (int i = 0; i < 5; i++) begin
            step4("rr_all", 1, 1, 0, 4'b1111, SEQ4, 1);
            check("rr_all.const_src",  64'(b4.out_src),  64'(exp_seq[i]));
            check("rr_all.const_data", 64'(b4.out_data), 64'(exp_seq[i]));
        end
        step4("rr_to_ptr2", 1, 1, 0, 4'b1111, SEQ4, 1);
        for (int i = 0; i < 4; i++) begin
            step4("rr_alt", 1, 1, 0, 4'b1010, SEQ4, 1);
            check("rr_alt.const_src", 64'(b4.out_src), 64'(alt_seq[i]));
        end

        // Backpressure: hold 1234 for three stalled cycles, then replace
        step4("bp_load", 1, 0, 0, 4'b0001, 64'h0000_0000_0000_1234, 1);
        for (int i = 0; i < 3; i++) begin
            step4("bp_stall", 1, 1, 0, 4'b1111, SEQ4, 0);
            check("bp_stall.const_data", 64'(b4.out_data), 64'h1234);
        end
        step4("bp_replace", 1, 1, 0, 4'b1111, SEQ4, 1);
        check("bp_replace.const_valid", 64'(b4.out_valid), 64'd1);
        check("bp_replace.const_src",   64'(b4.out_src),   64'd2);

        // Enable: drain with en=0, ptr frozen, resume at channel 3
        step4("en_off_drain", 0, 1, 0, 4'b1111, SEQ4, 1);
        check("en_off_drain.const_valid", 64'(b4.out_valid), 64'd0);
        step4("en_off_idle", 0, 1, 0, 4'b1111, SEQ4, 1);
        step4("en_resume", 1, 1, 0, 4'b1111, SEQ4, 1);
        check("en_resume.const_src", 64'(b4.out_src), 64'd3);

        // ptr retained across a fixed-mode grant
        step4("mode_rr", 1, 1, 0, 4'b1111, SEQ4, 1);
        step4("mode_fix", 1, 0, 3, 4'b1111, SEQ4, 1);
        step4("mode_back", 1, 1, 0, 4'b1111, SEQ4, 1);
        check("mode_back.const_src", 64'(b4.out_src), 64'd1);

        // Randomized traffic, N=4
        for (int i = 0; i < 400; i++) begin
            step4("rand4", $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 4'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 3) != 0);
        end

        // Reset mid-stream with a word held
        step4("pre_reset", 1, 1, 0, 4'b1111, SEQ4, 1);
        check("pre_reset.const_valid", 64'(b4.out_valid), 64'd1);
        b4.out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step4("post_reset", 1, 1, 0, 4'b1111, SEQ4, 1);
        check("post_reset.const_src", 64'(b4.out_src), 64'd0);
        b4.in_valid = '0;

        // N=3 instance: out-of-range select, then wrap 2 -> 0
        step3("n3_sel3", 1, 0, 3, 3'b111, SEQ3, 1);
        check("n3_sel3.const_valid", 64'(b3.out_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step3("n3_rr", 1, 1, 0, 3'b111, SEQ3, 1);
            check("n3_rr.const_src",  64'(b3.out_src),  64'(n3_seq[i]));
            check("n3_rr.const_data", 64'(b3.out_data), 64'(n3_seq[i]));
        end
        for (int i = 0; i < 300; i++) begin
            step3("rand3", $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 3'($urandom), {$urandom, $urandom, $urandom},
                  $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
